// File: rtl/evm_pkg.sv
// Shared types and constants for the EVM booth session controller.
// State encodings are fixed because state_code is exported to the datapath.
package evm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_AUTH     = 3'd1,
    ST_READY    = 3'd2,
    ST_LOOKUP   = 3'd3,
    ST_BALLOT   = 3'd4,
    ST_COOLDOWN = 3'd5,
    ST_CLOSED   = 3'd6,
    ST_RESULT   = 3'd7
  } state_e;

  localparam int VOTES_W    = 8;
  localparam int TIMEOUTS_W = 4;

  localparam int DEF_BALLOT_TIMEOUT  = 1000;
  localparam int DEF_COOLDOWN_CYCLES = 8;
  localparam int DEF_MAX_VOTES       = 255;
  localparam int DEF_TIMER_WIDTH     = 16;

  // ID lookup takes two cycles; the timer reaches this value on the second one.
  localparam int LOOKUP_LAST = 1;

  function automatic logic [VOTES_W-1:0] sat_inc_votes(input logic [VOTES_W-1:0] v);
    return (v == '1) ? v : v + VOTES_W'(1);
  endfunction

  function automatic logic [TIMEOUTS_W-1:0] sat_inc_timeouts(input logic [TIMEOUTS_W-1:0] v);
    return (v == '1) ? v : v + TIMEOUTS_W'(1);
  endfunction

endpackage

// File: rtl/evm_session_timer.sv
// Loadable up-counter with terminal-count flag, shared by LOOKUP, BALLOT and COOLDOWN.
module evm_session_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             inc,
  input  logic [WIDTH-1:0] terminal,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (inc) begin
      count <= count + WIDTH'(1);
    end
  end

  assign tc = (count == terminal);

endmodule

// File: rtl/evm_session_controller.sv
// Booth session sequencer: officer auth, voter admission, timed ballot, cooldown, results.
// Moore outputs decoded from the registered state; counters and voter_reject are registered.
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   IDLE     | no session, waiting for start_session
//   AUTH     | one cycle: check officer ID
//   READY    | session open, waiting for a voter or close
//   LOOKUP   | two cycles: voter ID read, eligibility sampled on 2nd
//   BALLOT   | buttons armed until vote or timeout
//   COOLDOWN | ballot locked for COOLDOWN_CYCLES
//   CLOSED   | session closed, officer may request results or reopen
//   RESULT   | results displayed while result_request is held
module evm_session_controller
  import evm_pkg::*;
#(
  parameter int BALLOT_TIMEOUT  = DEF_BALLOT_TIMEOUT,
  parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
  parameter int MAX_VOTES       = DEF_MAX_VOTES,
  parameter int TIMER_WIDTH     = DEF_TIMER_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_session,
  input  logic                  officer_id_status,
  input  logic                  voter_present,
  input  logic                  voter_eligible,
  input  logic                  vote_cast,
  input  logic                  end_session,
  input  logic                  result_request,
  output logic                  mode,
  output logic                  control,
  output logic                  read_enable,
  output logic                  ballot_enable,
  output logic                  show_result,
  output logic                  voter_reject,
  output logic [2:0]            state_code,
  output logic [VOTES_W-1:0]    session_votes,
  output logic [TIMEOUTS_W-1:0] timeout_count
);

  state_e state, next_state;

  logic [TIMER_WIDTH-1:0] timer_count;
  logic [TIMER_WIDTH-1:0] timer_terminal;
  logic                   timer_tc;
  logic                   timer_load;
  logic                   timer_inc;

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:     if (start_session) next_state = ST_AUTH;
      ST_AUTH:     next_state = officer_id_status ? ST_READY : ST_IDLE;
      ST_READY: begin
        if (end_session)                                 next_state = ST_CLOSED;
        else if (session_votes == VOTES_W'(MAX_VOTES))  next_state = ST_CLOSED;
        else if (voter_present)                          next_state = ST_LOOKUP;
      end
      ST_LOOKUP:   if (timer_tc) next_state = voter_eligible ? ST_BALLOT : ST_READY;
      ST_BALLOT:   if (vote_cast || timer_tc) next_state = ST_COOLDOWN;
      ST_COOLDOWN: if (timer_tc) next_state = ST_READY;
      ST_CLOSED: begin
        if (result_request)     next_state = ST_RESULT;
        else if (start_session) next_state = ST_AUTH;
      end
      ST_RESULT:   if (!result_request) next_state = ST_CLOSED;
      default:     next_state = ST_IDLE;
    endcase
  end

  // Every state change restarts the timer, so each timed state begins counting at zero.
  always_comb begin
    timer_terminal = '0;
    case (state)
      ST_LOOKUP:   timer_terminal = TIMER_WIDTH'(LOOKUP_LAST);
      ST_BALLOT:   timer_terminal = TIMER_WIDTH'(BALLOT_TIMEOUT - 1);
      ST_COOLDOWN: timer_terminal = TIMER_WIDTH'(COOLDOWN_CYCLES - 1);
      default:     timer_terminal = '0;
    endcase
  end

  assign timer_load = (next_state != state);
  assign timer_inc  = (state == ST_LOOKUP) || (state == ST_BALLOT) || (state == ST_COOLDOWN);

  evm_session_timer #(
    .WIDTH (TIMER_WIDTH)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value ('0),
    .inc        (timer_inc),
    .terminal   (timer_terminal),
    .count      (timer_count),
    .tc         (timer_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      session_votes <= '0;
      timeout_count <= '0;
      voter_reject  <= 1'b0;
    end else begin
      state        <= next_state;
      voter_reject <= (state == ST_LOOKUP) && timer_tc && !voter_eligible;
      case (state)
        ST_AUTH: begin
          if (officer_id_status) begin
            session_votes <= '0;
            timeout_count <= '0;
          end
        end
        // A vote in the timeout cycle counts as a vote, not a timeout.
        ST_BALLOT: begin
          if (vote_cast)     session_votes <= sat_inc_votes(session_votes);
          else if (timer_tc) timeout_count <= sat_inc_timeouts(timeout_count);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mode          = 1'b0;
    control       = 1'b0;
    read_enable   = 1'b0;
    ballot_enable = 1'b0;
    show_result   = 1'b0;
    case (state)
      ST_AUTH:     control = 1'b1;
      ST_READY:    mode = 1'b1;
      ST_LOOKUP: begin
        mode        = 1'b1;
        read_enable = 1'b1;
      end
      ST_BALLOT: begin
        mode          = 1'b1;
        ballot_enable = 1'b1;
      end
      ST_COOLDOWN: mode = 1'b1;
      ST_CLOSED:   control = 1'b1;
      ST_RESULT: begin
        control     = 1'b1;
        show_result = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_code = state;

endmodule
